if_buf: RTL and testbench
=========================

IF_BUF -- requirements
Module: if_buf

Interface
REQ-001 SHALL provide parameter DEPTH, default 2, meaning buffer entries; legal values are 2, 4 and 8.
REQ-002 SHALL provide parameter NOP_INST, default 32'h00000013, meaning the instruction presented when no entry is valid.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port fvalid_in, input, 1, fetch word valid.
REQ-007 SHALL have port pc_in, input, 32, PC of the fetch word (from pc_if pc_out).
REQ-008 SHALL have port inst_in, input, 32, instruction word fetched at pc_in.
REQ-009 SHALL have port flush_in, input, 1, jump taken (same signal as the pc_if jump flag).
REQ-010 SHALL have port hold_out, output, 1, stall request to the pc stage hold input.
REQ-011 SHALL have port id_ready_in, input, 1, decode accepts the head entry.
REQ-012 SHALL have port id_valid_out, output, 1, head entry valid.
REQ-013 SHALL have port id_pc_out, output, 32, PC of the head entry.
REQ-014 SHALL have port id_inst_out, output, 32, instruction of the head entry.

Function
REQ-015 SHALL implement a circular FIFO of DEPTH {pc, inst} entries, with read and write pointers wrapping modulo DEPTH and a count in the range 0..DEPTH.
REQ-016 SHALL define push as fvalid_in & ~flush_in & (count != DEPTH).
REQ-017 SHALL define pop as id_valid_out & id_ready_in & ~flush_in.
REQ-018 SHALL apply a push and a pop in the same cycle together: count is unchanged, and both pointers advance.
REQ-019 SHALL drive hold_out = (count == DEPTH), decoded from registered count only, with no path from id_ready_in; when hold_out is high, an input word is dropped and pc_if re-presents the same pc.
REQ-020 SHALL, on flush_in high, clear count, the read pointer and the write pointer at the next edge, discard that cycle's input word and perform no pop; flush_in has priority over all other events.
REQ-021 SHALL drive id_valid_out = (count != 0).
REQ-022 SHALL drive id_pc_out and id_inst_out from the head entry when count != 0; otherwise it SHALL drive 32'h0 and NOP_INST.
REQ-023 SHALL give one cycle of latency from push to visibility at the outputs (without IFBUF_BYPASS_EN).
REQ-024 SHALL keep the head entry and id_valid_out stable while id_valid_out & ~id_ready_in & ~flush_in holds.

Reset
REQ-025 SHALL, on rst high, asynchronously force count=0 and pointers=0, giving id_valid_out=0, id_pc_out=0, id_inst_out=NOP_INST and hold_out=0.
REQ-026 SHALL, on reset asserted mid-operation, discard all stored entries; storage contents need not be cleared.

Configuration
REQ-027 SHALL, with macro IFBUF_BYPASS_EN defined, forward the input directly when count==0 & fvalid_in & ~flush_in: id_valid_out=1, id_pc_out=pc_in and id_inst_out=inst_in in the same cycle.
REQ-028 SHALL, in that bypass case, not store the word if id_ready_in=1, and store it normally if id_ready_in=0.
REQ-029 SHALL, without IFBUF_BYPASS_EN, have no combinational path from any input to id_valid_out, id_pc_out or id_inst_out.

Verification
REQ-030 SHALL cover: reset, then 3 words at pc 0x0/0x4/0x8 with id_ready_in=1 -> outputs appear one cycle later in order with matching inst values, and hold_out=0 throughout.
REQ-031 SHALL cover: DEPTH=2 with id_ready_in=0 and 3 words pushed -> hold_out=1 after 2 words, the third is dropped, and pc 0x0 is held at the head.
REQ-032 SHALL cover: buffer full with push and pop in one cycle -> the push is rejected, count goes to 1, and the next word is accepted the following cycle.
REQ-033 SHALL cover: 2 entries held, then flush_in=1 with fvalid_in=1 at pc 0x40 -> next cycle id_valid_out=0, id_inst_out=0x00000013, and the 0x40 word is not stored.
REQ-034 SHALL cover: rst pulsed while 1 entry is held -> outputs return to reset values asynchronously, with no pop observed.
REQ-035 SHALL cover: IFBUF_BYPASS_EN with an empty buffer, pc_in=0x10, inst_in=0x00100093 and id_ready_in=1 -> same-cycle id_valid_out=1 and id_pc_out=0x10, with count remaining 0.

Source files
------------

// File: rtl/if_buf.sv
// ----------------------------------------------------------------------------
// if_buf -- instruction fetch buffer between the pc/fetch stage and decode.
//
// A small circular FIFO of {pc, inst} pairs. Fetch words are pushed when
// fvalid_in is high and there is room. Decode pops the head entry with
// id_ready_in. A taken jump (flush_in) empties the buffer and drops that
// cycle's fetch word. When the buffer is full, hold_out stalls the pc stage
// so the dropped word is re-presented.
//
// Parameters:
//   DEPTH     buffer entries (2, 4 or 8)
//   NOP_INST  instruction presented when no entry is valid
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   fvalid_in    fetch word valid
//   pc_in        PC of the fetch word
//   inst_in      instruction fetched at pc_in
//   flush_in     jump taken; clears the buffer at the next edge
//   hold_out     stall request to the pc stage (buffer full)
//   id_ready_in  decode accepts the head entry
//   id_valid_out head entry valid
//   id_pc_out    PC of the head entry (0 when empty)
//   id_inst_out  instruction of the head entry (NOP_INST when empty)
//
// Build option:
//   IFBUF_BYPASS_EN  when defined, an empty buffer forwards the incoming
//                    fetch word to the decode outputs in the same cycle.
// ----------------------------------------------------------------------------
module if_buf #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fvalid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    input  logic        flush_in,
    output logic        hold_out,
    input  logic        id_ready_in,
    output logic        id_valid_out,
    output logic [31:0] id_pc_out,
    output logic [31:0] id_inst_out
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          wr_en;
    logic          rd_adv;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

`ifdef IFBUF_BYPASS_EN
    assign bypass = empty & fvalid_in & ~flush_in;
`else
    assign bypass = 1'b0;
`endif

    assign push = fvalid_in & ~flush_in & ~full;
    assign pop  = id_valid_out & id_ready_in & ~flush_in;

    // A bypassed word taken by decode in the same cycle is never stored, and
    // the pop it causes must not touch the (empty) FIFO.
    assign wr_en  = push & ~(bypass & id_ready_in);
    assign rd_adv = pop & ~bypass;

    // Hold depends on registered state only.
    assign hold_out = full;

    // Decode-side outputs.
`ifdef IFBUF_BYPASS_EN
    always_comb begin
        id_valid_out = 1'b0;
        id_pc_out    = 32'h0;
        id_inst_out  = NOP_INST;
        if (!empty) begin
            id_valid_out = 1'b1;
            id_pc_out    = pc_mem[rd_ptr_q];
            id_inst_out  = inst_mem[rd_ptr_q];
        end else if (bypass) begin
            id_valid_out = 1'b1;
            id_pc_out    = pc_in;
            id_inst_out  = inst_in;
        end
    end
`else
    always_comb begin
        id_valid_out = 1'b0;
        id_pc_out    = 32'h0;
        id_inst_out  = NOP_INST;
        if (!empty) begin
            id_valid_out = 1'b1;
            id_pc_out    = pc_mem[rd_ptr_q];
            id_inst_out  = inst_mem[rd_ptr_q];
        end
    end
`endif

    // Next-state for pointers and occupancy; flush wins over everything.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush_in) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_adv) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({wr_en, rd_adv})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]   <= pc_in;
            inst_mem[wr_ptr_q] <= inst_in;
        end
    end

endmodule

// File: tb/tb_if_buf.sv
// ----------------------------------------------------------------------------
// tb_if_buf -- self-checking bench for if_buf. A queue-based model of the
// buffer predicts the decode outputs and hold each cycle; directed scenarios
// pin the model with literal expectations, then randomized traffic follows.
// ----------------------------------------------------------------------------
module tb_if_buf;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] NOP_INST = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        fvalid_in;
    logic [31:0] pc_in;
    logic [31:0] inst_in;
    logic        flush_in;
    logic        hold_out;
    logic        id_ready_in;
    logic        id_valid_out;
    logic [31:0] id_pc_out;
    logic [31:0] id_inst_out;

    if_buf #(
        .DEPTH    (DEPTH),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fvalid_in    (fvalid_in),
        .pc_in        (pc_in),
        .inst_in      (inst_in),
        .flush_in     (flush_in),
        .hold_out     (hold_out),
        .id_ready_in  (id_ready_in),
        .id_valid_out (id_valid_out),
        .id_pc_out    (id_pc_out),
        .id_inst_out  (id_inst_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: entries in arrival order, {pc, inst}.
    logic [63:0] q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_bypass();
`ifdef IFBUF_BYPASS_EN
        return (q.size() == 0) && fvalid_in && !flush_in;
`else
        return 1'b0;
`endif
    endfunction

    // Compare all outputs with what the model says they must be right now.
    task automatic compare();
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_hold;
        e_hold = (q.size() == DEPTH);
        if (q.size() != 0) begin
            e_valid = 1'b1;
            e_pc    = q[0][63:32];
            e_inst  = q[0][31:0];
        end else if (model_bypass()) begin
            e_valid = 1'b1;
            e_pc    = pc_in;
            e_inst  = inst_in;
        end else begin
            e_valid = 1'b0;
            e_pc    = 32'h0;
            e_inst  = NOP_INST;
        end
        chk("model valid", {31'b0, id_valid_out}, {31'b0, e_valid});
        chk("model pc",    id_pc_out,             e_pc);
        chk("model inst",  id_inst_out,           e_inst);
        chk("model hold",  {31'b0, hold_out},     {31'b0, e_hold});
    endtask

    // Apply inputs away from the rising edge, then check.
    task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                         input logic fl, input logic rdy);
        @(negedge clk);
        fvalid_in   = fv;
        pc_in       = pc;
        inst_in     = inst;
        flush_in    = fl;
        id_ready_in = rdy;
        #1;
        compare();
    endtask

    // Advance the model by the edge the DUT is about to see, then take it.
    task automatic tick();
        bit full, byp, pop, push;
        if (flush_in) begin
            q.delete();
        end else begin
            full = (q.size() == DEPTH);
            byp  = model_bypass();
            pop  = id_ready_in && (q.size() != 0 || byp);
            push = fvalid_in && !full;
            if (!(byp && id_ready_in)) begin
                if (pop)  void'(q.pop_front());
                if (push) q.push_back({pc_in, inst_in});
            end
        end
        @(posedge clk);
    endtask

    // Pulse reset mid-cycle and check the outputs fall back without a clock.
    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        chk("async rst valid", {31'b0, id_valid_out}, 32'h0);
        chk("async rst pc",    id_pc_out,             32'h0);
        chk("async rst inst",  id_inst_out,           NOP_INST);
        chk("async rst hold",  {31'b0, hold_out},     32'h0);
        rst = 1'b0;
        q.delete();
    endtask

    initial begin
        rst         = 1'b1;
        fvalid_in   = 1'b0;
        pc_in       = 32'h0;
        inst_in     = 32'h0;
        flush_in    = 1'b0;
        id_ready_in = 1'b0;

        // Reset state.
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("reset valid", {31'b0, id_valid_out}, 32'h0);
        chk("reset pc",    id_pc_out,             32'h0);
        chk("reset inst",  id_inst_out,           32'h00000013);
        chk("reset hold",  {31'b0, hold_out},     32'h0);
        rst = 1'b0;
        tick();

        // Three words streamed with decode always ready.
        drive(1'b1, 32'h0, 32'hA0000001, 1'b0, 1'b1);
`ifndef IFBUF_BYPASS_EN
        chk("stream c0 valid", {31'b0, id_valid_out}, 32'h0);
`endif
        tick();
        drive(1'b1, 32'h4, 32'hA0000002, 1'b0, 1'b1);
`ifndef IFBUF_BYPASS_EN
        chk("stream c1 pc",   id_pc_out,   32'h0);
        chk("stream c1 inst", id_inst_out, 32'hA0000001);
`endif
        chk("stream c1 hold", {31'b0, hold_out}, 32'h0);
        tick();
        drive(1'b1, 32'h8, 32'hA0000003, 1'b0, 1'b1);
`ifndef IFBUF_BYPASS_EN
        chk("stream c2 pc",   id_pc_out,   32'h4);
        chk("stream c2 inst", id_inst_out, 32'hA0000002);
`endif
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
`ifndef IFBUF_BYPASS_EN
        chk("stream c3 pc",   id_pc_out,   32'h8);
        chk("stream c3 inst", id_inst_out, 32'hA0000003);
`endif
        chk("stream c3 hold", {31'b0, hold_out}, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("stream drained", {31'b0, id_valid_out}, 32'h0);
        tick();

        // Fill with decode stalled; third word must be dropped.
        drive(1'b1, 32'h0, 32'hB0000001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h4, 32'hB0000002, 1'b0, 1'b0);
        chk("fill hold after 1", {31'b0, hold_out}, 32'h0);
        tick();
        drive(1'b1, 32'h8, 32'hB0000003, 1'b0, 1'b0);
        chk("fill hold after 2", {31'b0, hold_out}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("fill head pc", id_pc_out, 32'h0);
        chk("fill still hold", {31'b0, hold_out}, 32'h1);

        // Full with push and pop together: push rejected, pop taken.
        drive(1'b1, 32'h8, 32'hB0000003, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h8, 32'hB0000003, 1'b0, 1'b0);
        chk("pp hold cleared", {31'b0, hold_out}, 32'h0);
        chk("pp head pc",      id_pc_out,         32'h4);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("pp refilled hold", {31'b0, hold_out}, 32'h1);

        // Flush with a word presented at 0x40.
        drive(1'b1, 32'h40, 32'hC0000040, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("flush valid", {31'b0, id_valid_out}, 32'h0);
        chk("flush inst",  id_inst_out,           32'h00000013);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("flush not stored", {31'b0, id_valid_out}, 32'h0);
        tick();

        // Reset while one entry is held.
        drive(1'b1, 32'h20, 32'hD0000020, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("pre-rst valid", {31'b0, id_valid_out}, 32'h1);
        chk("pre-rst pc",    id_pc_out,             32'h20);
        async_reset();
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("post-rst valid", {31'b0, id_valid_out}, 32'h0);
        tick();

`ifdef IFBUF_BYPASS_EN
        drive(1'b1, 32'h10, 32'h00100093, 1'b0, 1'b1);
        chk("bypass valid", {31'b0, id_valid_out}, 32'h1);
        chk("bypass pc",    id_pc_out,             32'h10);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("bypass not stored", {31'b0, id_valid_out}, 32'h0);
        tick();
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  $urandom() & 32'hFFFF_FFFC,
                  $urandom(),
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                  $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 199) == 0) async_reset();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
